ccr_unit: RTL and testbench
===========================

Name: ccr_unit

Overview:
- Condition-code register for the execute stage.
- Holds the Z/N/C flags and merges updates from four sources: the ALU, the jump decision unit (taken-jump flag clear), SETC/CLRC, and interrupt restore.
- Drives the flag vector consumed by the jump decision logic.
- Contains a small LIFO that saves flags on interrupt entry and restores them on RTI.

Parameters:
- DEPTH, 2, number of flag-save stack entries (≥1).
- PTR_W, 2, stack pointer width; must hold 0..DEPTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset (0 = reset)
- stall  in  1  1 = freeze all state this cycle
- alu_flag_we  in  3  per-bit ALU write enables
- alu_flags  in  3  ALU flag results {Z,N,C}
- jdu_we  in  1  taken-jump indication (jmp_sign)
- jdu_flags  in  3  post-jump flag vector from the jump unit
- setc  in  1  set carry
- clrc  in  1  clear carry
- int_save  in  1  interrupt entry; push current flags
- rti_restore  in  1  RTI; pop flags
- flags_out  out  3  current flags {Z[2],N[1],C[0]}
- stack_full  out  1  stack holds DEPTH entries
- stack_empty  out  1  stack holds 0 entries
- stk_err  out  1  sticky overflow/underflow/conflict error

Behaviour:
- Flag bit order everywhere: bit 2 = zero, bit 1 = negative, bit 0 = carry.
- Reset (async, reset=0):
  - flags register = 3'b000, stack pointer = 0, all stack entries = 0, stk_err = 0.
  - flags_out = 0, stack_empty = 1, stack_full = 0.
- All state updates occur on the rising clk edge while reset=1 and stall=0.
- stall=1: nothing changes, including the stack and stk_err; all inputs are ignored.
- Next-flag priority, highest first:
  1. rti_restore with stack non-empty: flags ← top entry; pointer decrements; all other sources ignored for all bits.
  2. jdu_we: flags ← jdu_flags for all three bits; ALU and SETC/CLRC ignored this cycle.
  3. Carry bit only: setc → C=1, clrc → C=0. If both are asserted, setc wins.
  4. Per bit i: alu_flag_we[i] ? alu_flags[i] : hold.
  - Bits not written by any source hold their value.
- int_save:
  - Pushes the flags register value before this cycle's update.
  - The same-cycle update still applies to the register.
  - Pointer increments.
- Push when full: no write, pointer unchanged, stk_err ← 1.
- Pop when empty: stack unchanged; restore is ignored, so priorities 2–4 apply; stk_err ← 1.
- int_save and rti_restore in the same cycle:
  - Stack and pointer unchanged, stk_err ← 1.
  - Flags take priorities 2–4 (no restore).
- stk_err clears only on reset.
- stack_full = (pointer == DEPTH); stack_empty = (pointer == 0). Both are derived from the registered pointer.
- Latency: without the optional feature, flags_out is the registered value; an update at edge k is visible after edge k.
- Reset asserted mid-operation: all state clears immediately, independent of clk; pending pushed entries are lost.

Optional Feature:
- Macro: CCR_BYPASS_EN.
- Defined: flags_out = the combinational next-flag value (same-cycle write-through), so a flag produced by the ALU in cycle k is seen by the jump logic in cycle k.
  - When stall=1, flags_out equals the registered value.
  - During reset, flags_out = 0.
- Undefined: flags_out = registered value only. stack_full, stack_empty and stk_err are unaffected in both cases.

Test Plan:
- Reset, then alu_flag_we=3'b111, alu_flags=3'b101 for one cycle → flags_out=3'b101 next cycle; stack_empty=1.
- Flags=3'b101, jdu_we=1 with jdu_flags=3'b001 and simultaneously alu_flag_we=3'b010, alu_flags=3'b010 → flags_out=3'b001 (jump clear wins, ALU N write dropped).
- Flags=3'b110, int_save=1 with alu_flags=3'b001 (we=3'b111) → flags_out=3'b001; then rti_restore=1 → flags_out=3'b110, stack_empty=1, stk_err=0.
- DEPTH=2: three int_save pulses from flags=3'b011 → stack_full=1 after the second pulse, stk_err=1 after the third. Two restores then return 3'b011 each, and stack_empty=1.
- rti_restore on an empty stack with setc=1, clrc=1 → C=1, other bits held, stk_err=1. Then assert stall=1 with alu_flag_we=3'b111 → flags unchanged.
- Mid-stream reset pulse (reset=0 for half a cycle, asynchronous to clk) while stack depth=1 → flags_out=0, stack_empty=1, stk_err=0 immediately. With CCR_BYPASS_EN, an ALU write of 3'b100 appears on flags_out in the same cycle.

Source files
------------

// File: rtl/ccr_unit.sv
// ccr_unit: execute-stage condition-code register {Z,N,C} with a small LIFO that
// saves the flags on interrupt entry and restores them on RTI.
// Optional build macro CCR_BYPASS_EN: flags_out shows the next-flag value in the
// same cycle (write-through) instead of the registered value.
module ccr_unit #(
   parameter int DEPTH = 2,
   parameter int PTR_W = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       stall,
   input  logic [2:0] alu_flag_we,
   input  logic [2:0] alu_flags,
   input  logic       jdu_we,
   input  logic [2:0] jdu_flags,
   input  logic       setc,
   input  logic       clrc,
   input  logic       int_save,
   input  logic       rti_restore,
   output logic [2:0] flags_out,
   output logic       stack_full,
   output logic       stack_empty,
   output logic       stk_err
);

   localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(DEPTH);

   logic [2:0]       flags_p1;
   logic [2:0]       flags_p0;
   logic [2:0]       stk [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] top_idx;
   logic [2:0]       top_val;
   logic             push_req;
   logic             pop_req;
   logic             do_push;
   logic             do_pop;
   logic             err_set;

   assign stack_full  = (ptr == FULL_PTR);
   assign stack_empty = (ptr == '0);

   // A simultaneous save and restore cancels both; each alone is honoured only when legal.
   assign push_req = int_save & ~rti_restore;
   assign pop_req  = rti_restore & ~int_save;
   assign do_push  = push_req & ~stack_full;
   assign do_pop   = pop_req & ~stack_empty;
   assign err_set  = (int_save & rti_restore) | (push_req & stack_full) | (pop_req & stack_empty);
   assign top_idx  = ptr - 1'b1;

   // Read the top-of-stack entry by compare so the index width never has to match the array.
   always_comb begin
      top_val = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (top_idx == PTR_W'(i)) top_val = stk[i];
      end
   end

   // Next-flag merge, lowest priority first so later assignments override.
   always_comb begin
      flags_p0 = flags_p1;
      for (int b = 0; b < 3; b++) begin
         if (alu_flag_we[b]) flags_p0[b] = alu_flags[b];
      end
      if (clrc) flags_p0[0] = 1'b0;
      if (setc) flags_p0[0] = 1'b1;
      if (jdu_we) flags_p0 = jdu_flags;
      if (do_pop) flags_p0 = top_val;
   end

   // Stage p0 -> p1: flag register, save stack, pointer and sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_p1 <= '0;
         ptr      <= '0;
         stk_err  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      end else if (!stall) begin
         flags_p1 <= flags_p0;
         if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (ptr == PTR_W'(i)) stk[i] <= flags_p1;
            end
            ptr <= ptr + 1'b1;
         end else if (do_pop) begin
            ptr <= ptr - 1'b1;
         end
         if (err_set) stk_err <= 1'b1;
      end
   end

`ifdef CCR_BYPASS_EN
   // Write-through: the jump logic sees this cycle's update; frozen and reset cases show the register.
   assign flags_out = !reset ? 3'b000 : (stall ? flags_p1 : flags_p0);
`else
   assign flags_out = flags_p1;
`endif

endmodule

// File: tb/tb_ccr_unit.sv
// tb_ccr_unit: directed bench for ccr_unit with hand-computed expected flags.
module tb_ccr_unit;

   logic       clk;
   logic       reset;
   logic       stall;
   logic [2:0] alu_flag_we;
   logic [2:0] alu_flags;
   logic       jdu_we;
   logic [2:0] jdu_flags;
   logic       setc;
   logic       clrc;
   logic       int_save;
   logic       rti_restore;
   logic [2:0] flags_out;
   logic       stack_full;
   logic       stack_empty;
   logic       stk_err;

   int tests_run = 0;
   int failed    = 0;

   ccr_unit #(.DEPTH(2), .PTR_W(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .alu_flag_we (alu_flag_we),
      .alu_flags   (alu_flags),
      .jdu_we      (jdu_we),
      .jdu_flags   (jdu_flags),
      .setc        (setc),
      .clrc        (clrc),
      .int_save    (int_save),
      .rti_restore (rti_restore),
      .flags_out   (flags_out),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stk_err     (stk_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      stall = 0; alu_flag_we = 0; alu_flags = 0; jdu_we = 0; jdu_flags = 0;
      setc = 0; clrc = 0; int_save = 0; rti_restore = 0;
   endtask

   // advance one rising edge and settle 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_flags(input logic [2:0] v);
      idle();
      alu_flag_we = 3'b111; alu_flags = v;
      tick();
      idle();
   endtask

   task automatic test_reset();
      reset = 0;
      idle();
      #3;
      tests_run++; if (flags_out !== 3'b000) begin failed++; $display("FAIL reset_flags got %b want 000", flags_out); end
      tests_run++; if (stack_empty !== 1'b1) begin failed++; $display("FAIL reset_empty got %b want 1", stack_empty); end
      tests_run++; if (stack_full !== 1'b0) begin failed++; $display("FAIL reset_full got %b want 0", stack_full); end
      tests_run++; if (stk_err !== 1'b0) begin failed++; $display("FAIL reset_err got %b want 0", stk_err); end
      alu_flag_we = 3'b111; alu_flags = 3'b111;
      tick();
      tests_run++; if (flags_out !== 3'b000) begin failed++; $display("FAIL reset_hold got %b want 000", flags_out); end
      idle();
      reset = 1;
   endtask

   task automatic test_alu();
      alu_flag_we = 3'b111; alu_flags = 3'b101;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b101) begin failed++; $display("FAIL alu_all got %b want 101", flags_out); end
      tests_run++; if (stack_empty !== 1'b1) begin failed++; $display("FAIL alu_empty got %b want 1", stack_empty); end
      alu_flag_we = 3'b001; alu_flags = 3'b010;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b100) begin failed++; $display("FAIL alu_carry_only got %b want 100", flags_out); end
      alu_flag_we = 3'b011; alu_flags = 3'b111;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b111) begin failed++; $display("FAIL alu_partial got %b want 111", flags_out); end
      load_flags(3'b101);
   endtask

   task automatic test_jdu_priority();
      jdu_we = 1; jdu_flags = 3'b001; alu_flag_we = 3'b010; alu_flags = 3'b010;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b001) begin failed++; $display("FAIL jdu_over_alu got %b want 001", flags_out); end
      jdu_we = 1; jdu_flags = 3'b110; setc = 1;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b110) begin failed++; $display("FAIL jdu_over_setc got %b want 110", flags_out); end
      clrc = 1; alu_flag_we = 3'b001; alu_flags = 3'b001;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b110) begin failed++; $display("FAIL clrc_over_alu got %b want 110", flags_out); end
   endtask

   task automatic test_save_restore();
      load_flags(3'b110);
      int_save = 1; alu_flag_we = 3'b111; alu_flags = 3'b001;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b001) begin failed++; $display("FAIL save_update got %b want 001", flags_out); end
      tests_run++; if (stack_empty !== 1'b0) begin failed++; $display("FAIL save_empty got %b want 0", stack_empty); end
      tests_run++; if (stack_full !== 1'b0) begin failed++; $display("FAIL save_full got %b want 0", stack_full); end
      rti_restore = 1; jdu_we = 1; jdu_flags = 3'b000; setc = 1;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b110) begin failed++; $display("FAIL restore_flags got %b want 110", flags_out); end
      tests_run++; if (stack_empty !== 1'b1) begin failed++; $display("FAIL restore_empty got %b want 1", stack_empty); end
      tests_run++; if (stk_err !== 1'b0) begin failed++; $display("FAIL restore_err got %b want 0", stk_err); end
   endtask

   task automatic test_underflow_stall();
      rti_restore = 1; setc = 1; clrc = 1;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b111) begin failed++; $display("FAIL underflow_flags got %b want 111", flags_out); end
      tests_run++; if (stk_err !== 1'b1) begin failed++; $display("FAIL underflow_err got %b want 1", stk_err); end
      tests_run++; if (stack_empty !== 1'b1) begin failed++; $display("FAIL underflow_empty got %b want 1", stack_empty); end
      stall = 1; alu_flag_we = 3'b111; alu_flags = 3'b000; int_save = 1;
      tick();
      tests_run++; if (flags_out !== 3'b111) begin failed++; $display("FAIL stall_flags got %b want 111", flags_out); end
      tests_run++; if (stack_empty !== 1'b1) begin failed++; $display("FAIL stall_stack got %b want 1", stack_empty); end
      idle();
      int_save = 1; rti_restore = 1; alu_flag_we = 3'b001; alu_flags = 3'b000;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b110) begin failed++; $display("FAIL conflict_flags got %b want 110", flags_out); end
      tests_run++; if (stack_empty !== 1'b1) begin failed++; $display("FAIL conflict_stack got %b want 1", stack_empty); end
   endtask

   task automatic test_overflow();
      #2 reset = 0;
      #2 reset = 1;
      tests_run++; if (stk_err !== 1'b0) begin failed++; $display("FAIL ovf_preclear got %b want 0", stk_err); end
      load_flags(3'b011);
      // push 011, flags become 010
      int_save = 1; alu_flag_we = 3'b111; alu_flags = 3'b010;
      tick();
      idle();
      tests_run++; if (stack_full !== 1'b0) begin failed++; $display("FAIL ovf_full1 got %b want 0", stack_full); end
      // push 010
      int_save = 1;
      tick();
      idle();
      tests_run++; if (stack_full !== 1'b1) begin failed++; $display("FAIL ovf_full2 got %b want 1", stack_full); end
      tests_run++; if (stk_err !== 1'b0) begin failed++; $display("FAIL ovf_err2 got %b want 0", stk_err); end
      // push refused, flags still update to 111
      int_save = 1; alu_flag_we = 3'b111; alu_flags = 3'b111;
      tick();
      idle();
      tests_run++; if (stk_err !== 1'b1) begin failed++; $display("FAIL ovf_err3 got %b want 1", stk_err); end
      tests_run++; if (flags_out !== 3'b111) begin failed++; $display("FAIL ovf_flags3 got %b want 111", flags_out); end
      rti_restore = 1;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b010) begin failed++; $display("FAIL ovf_pop1 got %b want 010", flags_out); end
      tests_run++; if (stack_full !== 1'b0) begin failed++; $display("FAIL ovf_pop1_full got %b want 0", stack_full); end
      rti_restore = 1;
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b011) begin failed++; $display("FAIL ovf_pop2 got %b want 011", flags_out); end
      tests_run++; if (stack_empty !== 1'b1) begin failed++; $display("FAIL ovf_pop2_empty got %b want 1", stack_empty); end
   endtask

   task automatic test_async_reset();
      load_flags(3'b111);
      int_save = 1;
      tick();
      idle();
      tests_run++; if (stack_empty !== 1'b0) begin failed++; $display("FAIL ar_depth1 got %b want 0", stack_empty); end
      #1 reset = 0;
      #1;
      tests_run++; if (flags_out !== 3'b000) begin failed++; $display("FAIL ar_flags got %b want 000", flags_out); end
      tests_run++; if (stack_empty !== 1'b1) begin failed++; $display("FAIL ar_empty got %b want 1", stack_empty); end
      tests_run++; if (stk_err !== 1'b0) begin failed++; $display("FAIL ar_err got %b want 0", stk_err); end
      #3 reset = 1;
      alu_flag_we = 3'b111; alu_flags = 3'b100;
      #1;
`ifdef CCR_BYPASS_EN
      tests_run++; if (flags_out !== 3'b100) begin failed++; $display("FAIL ar_bypass got %b want 100", flags_out); end
`else
      tests_run++; if (flags_out !== 3'b000) begin failed++; $display("FAIL ar_registered got %b want 000", flags_out); end
`endif
      tick();
      idle();
      tests_run++; if (flags_out !== 3'b100) begin failed++; $display("FAIL ar_after_edge got %b want 100", flags_out); end
      rti_restore = 1;
      tick();
      idle();
      tests_run++; if (stk_err !== 1'b1) begin failed++; $display("FAIL ar_lost_entry got %b want 1", stk_err); end
      tests_run++; if (flags_out !== 3'b100) begin failed++; $display("FAIL ar_lost_flags got %b want 100", flags_out); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_jdu_priority();
      test_save_restore();
      test_underflow_stall();
      test_overflow();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
